// File: rtl/btn_pkg.sv
// Shared definitions for the button input conditioner.
// Holds the auto-repeat state encoding, the counter width helper and the
// default cycle constants for a 100 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_REPEAT_DELAY = 50_000_000;
    localparam int DEF_REPEAT_RATE  = 10_000_000;

    // Width wide enough to hold 0 .. max(a,b,c)-1, never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, consecutive-sample debounce,
// registered press/release pulses and, when AUTOREPEAT_EN is defined,
// a hold auto-repeat FSM that adds extra press pulses.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          accept;
    logic          rise;
    logic          fall;
    logic          press_d;

    assign mismatch = (sync_q2 != btn_level);
    assign accept   = mismatch && (cnt == DB_LAST);
    assign rise     = accept && !btn_level;
    assign fall     = accept && btn_level;

    // Bring the asynchronous button into the clock domain through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive mismatched samples; accept the new level after enough of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (!mismatch) begin
            cnt <= '0;
        end else if (accept) begin
            cnt       <= '0;
            btn_level <= ~btn_level;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

    rpt_state_t    state;
    rpt_state_t    state_nx;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_nx;
    logic          rpt_pulse;

    // Auto-repeat state and interval counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
        end
    end

    // Hold timing: long initial delay, then a steady repeat; an accepted fall always wins.
    always_comb begin
        state_nx  = state;
        rcnt_nx   = '0;
        rpt_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nx = DELAY;
            end
            DELAY: begin
                if (fall) begin
                    state_nx = IDLE;
                end else if (rcnt == RD_LAST) begin
                    rpt_pulse = 1'b1;
                    state_nx  = REPEAT;
                end else begin
                    rcnt_nx = rcnt + CW'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_nx = IDLE;
                end else if (rcnt == RR_LAST) begin
                    rpt_pulse = 1'b1;
                end else begin
                    rcnt_nx = rcnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign press_d = rise | rpt_pulse;
`else
    assign press_d = rise;
`endif

    // Event pulses land on the same edge the debounced level changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= press_d;
            btn_release <= fall;
        end
    end

endmodule

// File: rtl/btn_input_ctrl.sv
// N-channel button input conditioner: one btn_chan per button plus the
// combined any_level flag. Define AUTOREPEAT_EN to enable hold auto-repeat.
module btn_input_ctrl
    import btn_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            any_level
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

    assign any_level = |btn_level;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Testbench for btn_input_ctrl with short debounce/repeat timings.
// Expected pulse events are queued by the stimulus and checked by a monitor.
module tb_btn_input_ctrl;

    localparam int N   = 5;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
    localparam int LAT = DB + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_level;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] level;
    } evt_t;

    evt_t         exp_q[$];
    evt_t         mon_e;
    int           cyc      = 0;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [N-1:0] mdl_level = '0;
    int           c;

    btn_input_ctrl #(
        .N_CH        (N),
        .DEBOUNCE_CYC(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_level  (any_level)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic applyStimulus(input logic [N-1:0] new_raw);
        btn_raw = new_raw;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushEvent(input int at, input logic [N-1:0] p, input logic [N-1:0] r);
        evt_t e;
        mdl_level = (mdl_level | p) & ~r;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        e.level = mdl_level;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse cycle must match the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if ((btn_press | btn_release) != '0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected event: press=%b release=%b, expected none (cycle %0d)",
                             btn_press, btn_release, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("event cycle", cyc, mon_e.cyc);
                    checkOutput("btn_press", 32'(btn_press), 32'(mon_e.press));
                    checkOutput("btn_release", 32'(btn_release), 32'(mon_e.rel));
                    checkOutput("btn_level", 32'(btn_level), 32'(mon_e.level));
                    checkOutput("any_level", 32'(any_level), 32'(|mon_e.level));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                $display("[TB] FAIL missed event: got no pulse, expected press=%b release=%b at cycle %0d",
                         exp_q[0].press, exp_q[0].rel, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        waitCycles(2);
        checkOutput("reset btn_level", 32'(btn_level), 32'd0);
        checkOutput("reset btn_press", 32'(btn_press), 32'd0);
        checkOutput("reset btn_release", 32'(btn_release), 32'd0);
        checkOutput("reset any_level", 32'(any_level), 32'd0);
        rst = 1'b0;
        waitCycles(3);

        $display("[TB] clean press on channel 0");
        c = cyc;
        applyStimulus(5'b00001);
        pushEvent(c + LAT, 5'b00001, 5'b00000);
        waitCycles(LAT - 1);
        checkOutput("level0 before latency", 32'(btn_level[0]), 32'd0);
        waitCycles(6);

        $display("[TB] bouncing channel 1");
        applyStimulus(5'b00011); waitCycles(2);
        applyStimulus(5'b00001); waitCycles(2);
        applyStimulus(5'b00011); waitCycles(2);
        applyStimulus(5'b00001); waitCycles(2);
        c = cyc;
        applyStimulus(5'b00011);
        pushEvent(c + LAT, 5'b00010, 5'b00000);
        waitCycles(10);

        $display("[TB] simultaneous press/release");
        c = cyc;
        applyStimulus(5'b01111);
        pushEvent(c + LAT, 5'b01100, 5'b00000);
        waitCycles(10);
        c = cyc;
        applyStimulus(5'b01100);
        pushEvent(c + LAT, 5'b00000, 5'b00011);
        waitCycles(10);
        c = cyc;
        applyStimulus(5'b00000);
        pushEvent(c + LAT, 5'b00000, 5'b01100);
        waitCycles(LAT - 1);
        checkOutput("any_level before release", 32'(any_level), 32'd1);
        waitCycles(1);
        checkOutput("any_level at release", 32'(any_level), 32'd0);
        waitCycles(5);

        $display("[TB] reset while channel 0 held");
        c = cyc;
        applyStimulus(5'b00001);
        pushEvent(c + LAT, 5'b00001, 5'b00000);
        waitCycles(8);
        rst = 1'b1;
        #1;
        checkOutput("mid reset btn_level", 32'(btn_level), 32'd0);
        checkOutput("mid reset btn_press", 32'(btn_press), 32'd0);
        checkOutput("mid reset btn_release", 32'(btn_release), 32'd0);
        checkOutput("mid reset any_level", 32'(any_level), 32'd0);
        mdl_level = '0;
        @(negedge clk);
        rst = 1'b0;
        c = cyc;
        pushEvent(c + LAT, 5'b00001, 5'b00000);
        waitCycles(10);

        $display("[TB] hold channel 4");
        c = cyc;
        applyStimulus(5'b10001);
        pushEvent(c + LAT, 5'b10000, 5'b00000);
`ifdef AUTOREPEAT_EN
        for (int k = 0; k < 7; k++) pushEvent(c + LAT + RD + RR * k, 5'b10000, 5'b00000);
`endif
        waitCycles(30);
        c = cyc;
        applyStimulus(5'b00001);
        pushEvent(c + LAT, 5'b00000, 5'b10000);
        waitCycles(25);

        checkOutput("expectation queue drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_input_ctrl.md
Name: btn_input_ctrl

Overview:
- Parametrised successor to the per-button debounce instances.
- Replaces N separate debounce cells with one N-channel input conditioner:
  - 2-flop synchroniser per channel
  - consecutive-sample debounce counter
  - one-cycle press/release event pulses
  - optional hold auto-repeat
- Sits between the board buttons and game logic (graph). Feeds both the clean levels and the edge events used for jump/move/effect.

Parameters:
- N_CH, 5, number of independent button channels.
- DEBOUNCE_CYC, 1000000, consecutive stable-mismatch cycles required to accept a new level (10 ms at 100 MHz); must be ≥ 2.
- REPEAT_DELAY, 50000000, cycles a level must stay high before the first auto-repeat pulse (AUTOREPEAT_EN only).
- REPEAT_RATE, 10000000, cycles between subsequent auto-repeat pulses (AUTOREPEAT_EN only); must be ≥ 1.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- btn_raw, input, N_CH, raw asynchronous button inputs, bit i = channel i.
- btn_level, output, N_CH, debounced level per channel.
- btn_press, output, N_CH, one-cycle pulse on accepted rise (and on auto-repeat).
- btn_release, output, N_CH, one-cycle pulse on accepted fall.
- any_level, output, 1, OR of btn_level.

Behaviour:
- Reset (async assert, sync-released use): clears synchroniser flops, counters, btn_level, btn_press, btn_release and any_level to 0.
- Synchroniser: two flops per channel; sync[i] lags btn_raw[i] by 2 clocks.
- Debounce per channel:
  - cnt counts consecutive cycles with sync[i] != btn_level[i].
  - Any cycle with sync == level clears cnt to 0; an interrupted mismatch restarts from 0.
  - On the cycle cnt == DEBOUNCE_CYC-1 while still mismatched: btn_level toggles and cnt clears, on the same edge.
  - Latency from a clean raw edge to the btn_level edge is exactly DEBOUNCE_CYC+2 clocks.
- Event pulses:
  - btn_press[i] is registered and high for exactly the cycle in which btn_level[i] first reads 1.
  - btn_release[i] behaves the same for the transition to 0.
  - Press and release never assert together on one channel.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- Counter width is clog2 of the largest of DEBOUNCE_CYC, REPEAT_DELAY and REPEAT_RATE; counters never wrap (held at clear when idle).
- Button held through reset release: treated as a new press; btn_press fires DEBOUNCE_CYC+2 cycles after rst falls.
- Reset asserted mid-debounce or mid-repeat aborts immediately, with no pending pulse afterwards.
- any_level is combinational from the btn_level register (no extra latency).

Optional Feature:
- Macro AUTOREPEAT_EN.
- Defined — per-channel repeat FSM with states IDLE, DELAY, REPEAT:
  - IDLE → DELAY on an accepted rise, rcnt=0.
  - DELAY: rcnt counts to REPEAT_DELAY-1, then btn_press pulses, go to REPEAT, rcnt=0.
  - REPEAT: btn_press pulses every REPEAT_RATE cycles.
  - Any accepted fall → IDLE from every state, with no repeat pulse in that cycle.
- Undefined: no repeat FSM or rcnt logic; btn_press fires only on the accepted rise.

Decomposition:
- Shared package btn_pkg holds:
  - repeat state typedef/localparams (IDLE=0, DELAY=1, REPEAT=2)
  - clog2-based counter width function
  - default cycle constants for 100 MHz
- Natural sub-module btn_chan: one channel (sync, debounce, pulses, repeat). btn_input_ctrl generates N_CH instances and the any_level OR.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_CH=5):
- Clean press: raw[0] 0→1 at cycle 0 and held → btn_level[0]=1 and btn_press[0] for one cycle at cycle 6; btn_release stays 0.
- Bounce: raw[1] toggles 1,0,1,0 every 2 cycles, then steady 1 → no pulse during bouncing; single btn_press[1] 6 cycles after the final rise.
- Release and simultaneity: raw[2] and raw[3] fall together after being accepted high → both btn_release pulse in the same cycle, 6 cycles later; any_level drops to 0 in that same cycle.
- Reset mid-operation: rst asserted for 1 cycle with raw[0]=1 held → all outputs 0 immediately; btn_press[0] again 6 cycles after rst deasserts.
- AUTOREPEAT_EN: raw[4] held high for 30 cycles → press at the accepted rise, then 10 and 13, 16, 19… cycles later; release after drop stops all repeats.
- AUTOREPEAT_EN undefined: same stimulus → exactly one btn_press[4].
